// File: rtl/mem_bus_adapter.sv
// rtl/mem_bus_adapter.sv - MEM-stage to request/ack data bus adapter
// One bus transaction per aligned access; stalls the pipeline until ack or timeout.
module mem_bus_adapter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        addr_err,
  output logic        tmo_err,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        addr_err_q, addr_err_d;
  logic        tmo_err_q, tmo_err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic active;
  logic aligned;
  logic stall;

  assign active  = mem_ren | mem_wen;
  assign aligned = (mem_addr[1:0] == 2'b00);

  // The IDLE-cycle stall is combinational so the pipeline freezes on the same edge the access is accepted.
  assign stall = ((state_q == S_IDLE) && active && aligned) || (state_q == S_WAIT);

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    data_d      = data_q;
    tmo_cnt_d   = tmo_cnt_q;
    addr_err_d  = addr_err_q;
    tmo_err_d   = tmo_err_q;
    case (state_q)
      S_IDLE: begin
        if (active) begin
          if (aligned) begin
            bus_addr_d  = {mem_addr[31:2], 2'b00};
            bus_wdata_d = mem_dout;
            bus_we_d    = mem_wen;
            bus_req_d   = 1'b1;
            tmo_cnt_d   = 8'd0;
            state_d     = S_WAIT;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // An ack on the final timeout cycle still completes normally.
        if (bus_ack) begin
          data_d    = bus_we_q ? 32'd0 : bus_rdata;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          data_d    = bus_we_q ? 32'd0 : ERR_DATA;
          tmo_err_d = 1'b1;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      data_q      <= 32'd0;
      tmo_cnt_q   <= 8'd0;
      addr_err_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      data_q      <= data_d;
      tmo_cnt_q   <= tmo_cnt_d;
      addr_err_q  <= addr_err_d;
      tmo_err_q   <= tmo_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_din   = (state_q == S_DONE) ? data_q : 32'd0;
  assign mem_stall = stall;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign addr_err  = addr_err_q;
  assign tmo_err   = tmo_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// tb/tb_mem_bus_adapter.sv - scoreboard bench for mem_bus_adapter
module tb_mem_bus_adapter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_dout = 32'd0;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        addr_err;
  logic        tmo_err;
  logic [31:0] stall_cnt;

  mem_bus_adapter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .addr_err(addr_err), .tmo_err(tmo_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] din;
    int          stall_len;
    int          req_len;
    logic [31:0] scnt;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ack_delay = -1;
  logic [31:0] ack_data = 32'd0;
  int exp_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Bus responder: acks ack_delay cycles after bus_req rises; -1 never acks.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_req && rst_n) begin
        if (cnt == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = ack_data;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = 32'd0;
        end
        cnt++;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        cnt       = 0;
      end
    end
  end

  // Monitor: bus-side check on request rise, pipeline-side check on the DONE cycle.
  initial begin
    logic prev_stall, prev_req;
    int stall_run, req_run;
    exp_t e;
    prev_stall = 1'b0; prev_req = 1'b0; stall_run = 0; req_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0; prev_req = 1'b0; stall_run = 0; req_run = 0;
      end else begin
        if (bus_req && !prev_req) begin
          if (exp_q.size() > 0) begin
            chk("bus_addr", bus_addr, exp_q[0].addr);
            chk("bus_we", {31'd0, bus_we}, {31'd0, exp_q[0].we});
            chk("bus_wdata", bus_wdata, exp_q[0].wdata);
          end else begin
            chk("unexpected_req", 32'd1, 32'd0);
          end
        end
        if (bus_req) req_run++;
        if (mem_stall) stall_run++;
        if (!mem_stall && prev_stall) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_mem_din", mem_din, e.din);
            chk("stall_len", stall_run, e.stall_len);
            chk("req_len", req_run, e.req_len);
            chk("stall_cnt", stall_cnt, e.scnt);
            chk("tmo_err", {31'd0, tmo_err}, {31'd0, e.tmo});
          end else begin
            chk("unexpected_done", 32'd1, 32'd0);
          end
          stall_run = 0;
          req_run = 0;
          done_cnt++;
        end
        prev_stall = mem_stall;
        prev_req = bus_req;
      end
    end
  end

  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] dout, input int delay, input logic [31:0] rdata,
                           input logic [31:0] exp_din, input int stall_len, input int req_len,
                           input logic exp_tmo);
    exp_t e;
    int start;
    bit seen;
    exp_total += stall_len;
    e.addr = {addr[31:2], 2'b00}; e.we = wen; e.wdata = dout; e.din = exp_din;
    e.stall_len = stall_len; e.req_len = req_len; e.scnt = exp_total; e.tmo = exp_tmo;
    exp_q.push_back(e);
    ack_delay = delay;
    ack_data = rdata;
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = dout;
    start = done_cnt;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("access_completion", 32'd0, 32'd1);
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'd0; mem_dout = 32'd0;
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned read, ack 2 cycles after request.
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'd0, 2, 32'h1234_5678, 32'h1234_5678, 4, 3, 1'b0);
    // Both ren and wen set: write, immediate ack.
    do_access(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'hFFFF_FFFF, 32'd0, 2, 1, 1'b0);

    // Misaligned read.
    mem_ren = 1'b1; mem_addr = 32'h0000_0013;
    @(negedge clk);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    chk("mis_din", mem_din, 32'd0);
    chk("mis_addr_err_pre", {31'd0, addr_err}, 32'd0);
    @(posedge clk);
    #1;
    chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
    chk("mis_bus_req", {31'd0, bus_req}, 32'd0);
    mem_ren = 1'b0; mem_addr = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("mis_addr_err_sticky", {31'd0, addr_err}, 32'd1);
    chk("mis_stall_cnt", stall_cnt, 32'd6);

    // Ack on the last timeout cycle, then a real timeout.
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'd0, 3, 32'h5A5A_1234, 32'h5A5A_1234, 5, 4, 1'b0);
    do_access(1'b1, 1'b0, 32'h0000_0080, 32'd0, -1, 32'd0, 32'hDEAD_BEEF, 5, 4, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("tmo_err_sticky", {31'd0, tmo_err}, 32'd1);

    // Reset while in WAIT.
    e.addr = 32'h0000_0040; e.we = 1'b0; e.wdata = 32'd0; e.din = 32'd0;
    e.stall_len = 0; e.req_len = 0; e.scnt = 32'd0; e.tmo = 1'b0;
    exp_q.push_back(e);
    ack_delay = -1;
    mem_ren = 1'b1; mem_addr = 32'h0000_0040;
    repeat (3) @(posedge clk);
    #1;
    chk("wait_bus_req", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0;
    mem_ren = 1'b0; mem_addr = 32'd0;
    #1;
    chk("arst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("arst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    chk("arst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("arst_tmo_err", {31'd0, tmo_err}, 32'd0);
    exp_q.delete();
    exp_total = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'd0, 1, 32'h8765_4321, 32'h8765_4321, 3, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_adapter.md
Name: mem_bus_adapter

Overview:
- Sits between the MEM stage of the 5-stage MIPS datapath and a variable-latency, request/acknowledge data bus.
- Consumes the MEM-stage access (mem_ren, mem_wen, mem_addr, mem_dout) and drives one bus transaction per access.
- Returns read data on mem_din and raises mem_stall so the pipeline controller holds all stages until the access completes.
- Also flags misaligned accesses and bus timeouts, and keeps a saturating stall-cycle counter for debug readout.

Parameters:
- TIMEOUT, 16, maximum number of WAIT cycles without bus_ack before the access is aborted (range 2..255).
- ERR_DATA, 32'hDEAD_BEEF, value returned on mem_din for an aborted read.

Ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_ren  in  1  MEM-stage read request.
- mem_wen  in  1  MEM-stage write request.
- mem_addr  in  32  byte address.
- mem_dout  in  32  write data.
- mem_din  out  32  read data to the MEM stage and the WB pipeline register.
- mem_stall  out  1  freeze request to the pipeline controller.
- bus_req  out  1  bus request; held until ack or abort.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address.
- bus_wdata  out  32  write data.
- bus_ack  in  1  one-cycle completion strobe.
- bus_rdata  in  32  read data, valid while bus_ack = 1.
- addr_err  out  1  sticky flag: misaligned access seen.
- tmo_err  out  1  sticky flag: timeout seen.
- stall_cnt  out  32  saturating count of cycles with mem_stall = 1.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (asynchronous, may arrive mid-transaction):
  - State goes to IDLE.
  - bus_req, bus_we, addr_err, tmo_err = 0.
  - bus_addr, bus_wdata, the data latch, the timeout counter and stall_cnt = 0.
  - bus_req drops in the same cycle, with no completion.
- An access is "active" when mem_ren | mem_wen. If both are set, the access is a write (wen wins). A read is never issued for that access.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Active and mem_addr[1:0] == 0:
    - mem_stall = 1, combinationally, in the same cycle.
    - At the clock edge, latch addr, data and we; set bus_req = 1; clear the timeout counter; go to WAIT.
  - Active and mem_addr[1:0] != 0:
    - No bus transaction; mem_stall = 0; mem_din = 0.
    - addr_err is set at the edge and stays set until reset.
  - Inactive: mem_stall = 0, mem_din = 0.
- WAIT:
  - mem_stall = 1; bus outputs are held stable.
  - bus_ack = 1: capture bus_rdata into the latch (writes capture 0); bus_req drops at the edge; go to DONE.
  - No ack: the counter increments. When the counter reaches TIMEOUT-1 with still no ack:
    - The latch takes ERR_DATA for a read, 0 for a write.
    - tmo_err is set (sticky); bus_req drops; go to DONE.
  - Ack and timeout in the same cycle: the ack wins and tmo_err is not set.
- DONE:
  - mem_stall = 0; mem_din = latch. The pipeline advances on this edge.
  - Go to IDLE unconditionally. The access present in DONE is the one just completed and is never reissued.
- Latency:
  - Read with ack N cycles after bus_req rises (N >= 0): mem_stall is high for N+2 cycles (1 IDLE + N+1 WAIT), then DONE for 1 cycle.
  - Minimum total is 3 cycles per aligned access.
- Back-to-back accesses: the next access is seen in the IDLE cycle after DONE, so there is no gap cycle beyond DONE→IDLE.
- bus_addr = {addr[31:2], 2'b00}.
- bus_ack received while not in WAIT is ignored.
- stall_cnt increments every cycle mem_stall = 1 and saturates at 32'hFFFF_FFFF.
- Inputs are sampled only in IDLE. Changes to mem_* during WAIT or DONE have no effect.

Test Plan:
- Aligned read: mem_ren=1, addr 0x0000_0010; bus acks 2 cycles after req with rdata 0x1234_5678.
  - Expect bus_addr = 0x10, bus_we = 0, mem_stall high for 4 cycles.
  - Expect DONE mem_din = 0x1234_5678 and stall_cnt = 4.
- Write with simultaneous ren/wen: addr 0x20, dout 0xCAFE_F00D, immediate ack.
  - Expect bus_we = 1, bus_wdata = 0xCAFE_F00D, stall high for 2 cycles.
  - Expect mem_din = 0 in DONE and no read issued.
- Misaligned read at 0x0000_0013: expect no bus_req, mem_stall = 0, mem_din = 0, addr_err = 1 from the next edge and persisting.
- Timeout with TIMEOUT=4 and ack never given: expect bus_req high for 4 cycles, then dropped; DONE mem_din = 0xDEAD_BEEF; tmo_err = 1.
- Ack on the final timeout cycle: expect normal completion with rdata, and tmo_err = 0.
- rst_n pulsed low while in WAIT: expect bus_req, mem_stall (IDLE, inactive), stall_cnt and both error flags = 0 immediately. A new read after release completes normally.
